// File: rtl/mult_arbiter_pkg.sv
// Shared types and default sizing for the multiplier arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int N_DEFAULT    = 32;
    localparam int F_DEFAULT    = 16;
    localparam int NREQ_DEFAULT = 4;

endpackage

// File: rtl/mult_arbiter_seq_mult_core.sv
// Iterative shift-add multiplier for M-bit unsigned magnitudes with fixed-point truncation.
// Latency: M step cycles after start; done is asserted in the cycle following the last step.
// Backpressure: none; the result is held until the next start, which also restarts the core.
module seq_mult_core #(
    parameter int M = 31,
    parameter int F = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] op_a,
    input  logic [M-1:0] op_b,
    output logic         done,
    output logic [M-1:0] product,
    output logic         ovf
);
    localparam int CW = $clog2(M + 1);

    logic [2*M-1:0] acc;
    logic [2*M-1:0] mcand;
    logic [M-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           busy;

    // Load on start, then one conditional add and shift per cycle until M steps are done.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{M{1'b0}}, op_a};
            mplier <= op_b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            if (cnt != CW'(M)) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end else begin
                busy <= 1'b0;
            end
        end
    end

    // Done pulses for one cycle once all steps are in; the fraction is cut, high bits flag overflow.
    always_comb begin
        done    = busy && (cnt == CW'(M));
        product = acc[M-1+F:F];
        ovf     = |acc[2*M-1:M+F];
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude fixed-point multiplier among NREQ requesters.
// Latency: resp_valid rises N cycles after the accepting edge.
// Backpressure: result is held in DONE until resp_ready; no requests are accepted until then.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int F    = F_DEFAULT,
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_a,
    input  logic [NREQ*N-1:0]       req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [N-1:0]            resp_c,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic                    resp_ovf
);
    localparam int IDW = $clog2(NREQ);
    localparam int M   = N - 1;

    arb_state_t     state;
    arb_state_t     state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] id_q;
    logic           grant_vld;
    logic           accept;
    logic           sign_q;
    logic [N-1:0]   sel_a;
    logic [N-1:0]   sel_b;
    logic           core_done;
    logic           core_ovf;
    logic [M-1:0]   core_mag;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping; lowest offset wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign sel_a = req_a[int'(grant_idx)*N +: N];
    assign sel_b = req_b[int'(grant_idx)*N +: N];

    // FSM state register; reset wins over any accept or response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: accept starts work, core done publishes, consumer handshake frees the unit.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = BUSY;
            BUSY:    if (core_done)  state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // FSM outputs: grant strobe only while idle, response valid only while done.
    always_comb begin
        req_ready  = '0;
        accept     = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                end
            end
            DONE:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Capture owner and sign at accept; capture the response once the core finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            id_q     <= '0;
            sign_q   <= 1'b0;
            resp_c   <= '0;
            resp_id  <= '0;
            resp_ovf <= 1'b0;
        end else begin
            if (accept) begin
                id_q   <= grant_idx;
                sign_q <= sel_a[N-1] ^ sel_b[N-1];
                rr_ptr <= IDW'((int'(grant_idx) + 1) % NREQ);
            end
            if ((state == BUSY) && core_done) begin
                // A zero magnitude never carries a sign.
                resp_c   <= {sign_q && (core_mag != '0), core_mag};
                resp_id  <= id_q;
                resp_ovf <= core_ovf;
            end
        end
    end

    seq_mult_core #(
        .M (M),
        .F (F)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .op_a    (sel_a[M-1:0]),
        .op_b    (sel_b[M-1:0]),
        .done    (core_done),
        .product (core_mag),
        .ovf     (core_ovf)
    );

endmodule
